mips_pc_sequencer: RTL and testbench
====================================

Name: mips_pc_sequencer

Overview:
- Parametrised successor to the single-cycle PC logic. Owns the program counter and next-PC selection: sequential, jump, jr, branch and jal.
- Adds byte/word addressing, a stall hold, and a hardware return-address stack (RAS) that replaces the lone ra register.
- Sits between decode/control (which supply decoded transfer strobes) and instruction memory (which consumes `pc`).

Parameters:
- ADDR_W, 32, PC width in bits (must be ≥ 28).
- INC, 1, PC increment per instruction. Only 1 (word-addressed) or 4 (byte-addressed) is legal. SH = log2(INC).
- RESET_PC, 0, PC value after reset.
- RAS_DEPTH, 4, return-stack entries. Must be a power of two, ≥ 2.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all state this cycle
- is_jump  in  1  j instruction
- is_jal  in  1  jal instruction
- is_jr  in  1  jr instruction
- jr_is_ret  in  1  the jr source is $31; target comes from the RAS
- branch_taken  in  1  branch condition already resolved true
- imm  in  16  branch offset, in instructions, signed
- jaddr  in  26  jump field
- jr_target  in  ADDR_W  register-file value of rs
- pc  out  ADDR_W  current PC
- link_addr  out  ADDR_W  RAS top entry (0 when empty)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries in the RAS
- ras_overflow  out  1  sticky: a push happened while full
- ras_underflow  out  1  sticky: a pop happened while empty

Behaviour:
- Reset (synchronous, takes priority over everything including stall):
  - pc = RESET_PC; RAS emptied; ras_count = 0; link_addr = 0; both sticky flags = 0; delay-slot state returns to NORMAL.
- All updates occur on the rising edge of clock. pc is a register, so a new target is visible one cycle after the strobes.
- stall = 1: pc, RAS, flags and state all hold. No push or pop occurs.
- Next-PC priority (first match wins):
  1. is_jump: target = {pcp[ADDR_W-1:26+SH], jaddr, SH'b0}, where pcp = pc + INC.
  2. is_jr: if jr_is_ret and RAS non-empty, pop; target = popped entry. Otherwise target = jr_target. If jr_is_ret and the RAS is empty, set ras_underflow and use jr_target.
  3. branch_taken: target = pcp + (sign-extend(imm) << SH). Arithmetic is modulo 2^ADDR_W.
  4. is_jal: push pcp; target = the is_jump formula.
  5. Otherwise: pc = pcp.
- Only the winning strobe takes effect. Example: is_jump together with is_jal performs no push.
- Link value is pc + INC, the return address. It is not the jal's own PC.
- RAS is a circular buffer:
  - Push when full overwrites the oldest entry, sets ras_overflow, and leaves ras_count = RAS_DEPTH.
  - link_addr is combinational from the top entry.
- Wrap-around: pc increments past all-ones wrap to 0 with no flag.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MIPS_PC_DELAY_SLOT_EN.
- Defined: adds a two-state FSM, NORMAL and SLOT.
  - In NORMAL, any taken transfer (items 1–4) latches its target into pend_target. Push/pop is applied, pc ← pcp, state → SLOT.
  - In SLOT, on the next non-stalled edge: pc ← pend_target and state → NORMAL. All transfer strobes are ignored in SLOT, with no push/pop.
  - A jal in this mode pushes pc + 2·INC.
  - Reset in SLOT drops the pending target.
- Undefined: no FSM. Transfers take effect on the same edge, as described above.

Decomposition:
- Package mips_pc_pkg holds:
  - the NORMAL/SLOT state encoding;
  - a next-PC select enum (SEL_SEQ, SEL_JUMP, SEL_JR, SEL_BR, SEL_JAL);
  - the constant function computing SH from INC.
- One sub-module, mips_ras, owns the stack:
  - ports: clock, reset, push, pop, push_data, top, count, ovf, unf;
  - pop-while-empty returns 0.
- The top level holds the PC register, the priority select and the optional FSM.

Test Plan (defaults unless stated):
1. Reset with stall=1, then release, 3 idle cycles → pc 0, 0, 1, 2, 3.
2. At pc=5, branch_taken with imm=16'hFFFD → next pc 3. With INC=4, at pc=20 and imm=-3 → next pc 12.
3. At pc=7, is_jal with jaddr=40 → pc 40, link_addr 8, ras_count 1. Then is_jr with jr_is_ret=1 and jr_target=99 → pc 8, ras_count 0.
4. Five jals from pcs 0, 10, 20, 30, 40 (RAS_DEPTH=4) → ras_overflow=1. Five returns yield 41, 31, 21, 11, then jr_target on the fifth, and ras_underflow=1.
5. is_jump and branch_taken together at pc=2 with jaddr=9 → pc 9. Repeat with stall=1 → pc holds at 2 and ras_count is unchanged.
6. With MIPS_PC_DELAY_SLOT_EN, at pc=4, is_jump with jaddr=30 → pc 5, then 30. A jal presented during the slot is ignored (ras_count 0). Reset asserted during the slot → pc 0, and the pending target is lost.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// mips_pc_pkg: shared state/select encodings and PC shift helper for mips_pc_sequencer
package mips_pc_pkg;
  typedef enum logic {NORMAL, SLOT} state_e;
  typedef enum logic [2:0] {SEL_SEQ, SEL_JUMP, SEL_JR, SEL_BR, SEL_JAL} sel_e;
  function automatic int calc_sh(input int inc);
    return (inc == 4) ? 2 : 0;
  endfunction
endpackage

// File: rtl/mips_ras.sv
// mips_ras: circular return-address stack; full push overwrites oldest, empty pop reads 0
module mips_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [AW:0] cnt_q;
  logic ovf_q, unf_q, full, empty;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign top   = empty ? '0 : mem_q[ptr_q - AW'(1)];
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  // pointer, occupancy and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= push ? ptr_q + AW'(1) : (pop && !empty) ? ptr_q - AW'(1) : ptr_q;
      cnt_q <= push ? (full ? cnt_q : cnt_q + (AW+1)'(1)) : (pop && !empty) ? cnt_q - (AW+1)'(1) : cnt_q;
      ovf_q <= ovf_q | (push & full);
      unf_q <= unf_q | (pop & empty);
    end
  end
  // entry storage; validity is tracked by the count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[ptr_q] <= push_data;
  end
endmodule

// File: rtl/mips_pc_sequencer.sv
// mips_pc_sequencer: PC register, next-PC priority select and RAS; MIPS_PC_DELAY_SLOT_EN adds a branch delay slot
module mips_pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INC       = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         is_jump,
  input  logic                         is_jal,
  input  logic                         is_jr,
  input  logic                         jr_is_ret,
  input  logic                         branch_taken,
  input  logic [15:0]                  imm,
  input  logic [25:0]                  jaddr,
  input  logic [ADDR_W-1:0]            jr_target,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            link_addr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);
  localparam int SH = calc_sh(INC);
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'((64'd1 << (26 + SH)) - 64'd1);
  sel_e sel;
  logic [ADDR_W-1:0] pc_q, pc_d, pcp, jtgt, btgt, tgt, link_val;
  logic xfer_en, push, pop;
  assign pcp  = pc_q + ADDR_W'(INC);
  assign jtgt = (pcp & ~JMASK) | (ADDR_W'(jaddr) << SH);
  assign btgt = pcp + ({{(ADDR_W-16){imm[15]}}, imm} << SH);
  assign pc   = pc_q;
  // first matching strobe wins: jump, jr, branch, jal, sequential
  always_comb begin
    sel = is_jump ? SEL_JUMP : is_jr ? SEL_JR : branch_taken ? SEL_BR : is_jal ? SEL_JAL : SEL_SEQ;
    tgt = (sel == SEL_JUMP || sel == SEL_JAL) ? jtgt :
          (sel == SEL_JR) ? ((jr_is_ret && ras_count != '0) ? link_addr : jr_target) :
          (sel == SEL_BR) ? btgt : pcp;
  end
  assign push = xfer_en && sel == SEL_JAL;
  assign pop  = xfer_en && sel == SEL_JR && jr_is_ret;
`ifdef MIPS_PC_DELAY_SLOT_EN
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  assign link_val = pcp + ADDR_W'(INC);
  assign xfer_en  = !stall && state_q == NORMAL;
  // a taken transfer runs the delay-slot instruction first, then lands on the latched target
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    if (!stall) begin
      if (state_q == SLOT) begin
        pc_d    = pend_q;
        state_d = NORMAL;
      end else begin
        pc_d = pcp;
        if (sel != SEL_SEQ) begin
          pend_d  = tgt;
          state_d = SLOT;
        end
      end
    end
  end
  // delay-slot state and pending target
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= NORMAL;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end
`else
  assign link_val = pcp;
  assign xfer_en  = !stall;
  assign pc_d     = stall ? pc_q : tgt;
`endif
  // program counter register
  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  mips_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (link_val),
    .top       (link_addr),
    .count     (ras_count),
    .ovf       (ras_overflow),
    .unf       (ras_underflow)
  );
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// tb_mips_pc_sequencer: directed vectors with hand-computed expectations for mips_pc_sequencer
module tb_mips_pc_sequencer;
  logic clock = 1'b0;
  logic reset, stall, is_jump, is_jal, is_jr, jr_is_ret, branch_taken;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [31:0] jr_target, pc, link_addr, pc4, link4;
  logic [2:0] ras_count, cnt4;
  logic ras_overflow, ras_underflow, ovf4, unf4;
  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  mips_pc_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .is_jump(is_jump), .is_jal(is_jal),
    .is_jr(is_jr), .jr_is_ret(jr_is_ret), .branch_taken(branch_taken), .imm(imm),
    .jaddr(jaddr), .jr_target(jr_target), .pc(pc), .link_addr(link_addr),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  mips_pc_sequencer #(.INC(4)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .is_jump(is_jump), .is_jal(is_jal),
    .is_jr(is_jr), .jr_is_ret(jr_is_ret), .branch_taken(branch_taken), .imm(imm),
    .jaddr(jaddr), .jr_target(jr_target), .pc(pc4), .link_addr(link4),
    .ras_count(cnt4), .ras_overflow(ovf4), .ras_underflow(unf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic j, input logic jl, input logic jr, input logic rt, input logic br,
                     input logic [15:0] im, input logic [25:0] ja, input logic [31:0] jt);
    is_jump = j; is_jal = jl; is_jr = jr; jr_is_ret = rt; branch_taken = br;
    imm = im; jaddr = ja; jr_target = jt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1;
    is_jump = 0; is_jal = 0; is_jr = 0; jr_is_ret = 0; branch_taken = 0;
    imm = '0; jaddr = '0; jr_target = '0;
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_pc4", pc4, 32'd0);
    check("rst_cnt", {29'd0, ras_count}, 32'd0);
    check("rst_link", link_addr, 32'd0);
    check("rst_ovf", {31'd0, ras_overflow}, 32'd0);
    check("rst_unf", {31'd0, ras_underflow}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    #1;
    check("rel_pc", pc, 32'd0);
`ifndef MIPS_PC_DELAY_SLOT_EN
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("seq1", pc, 32'd1);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("seq2", pc, 32'd2);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("seq3", pc, 32'd3);
    check("seq3_inc4", pc4, 32'd12);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("pre_br", pc, 32'd5);
    check("pre_br_inc4", pc4, 32'd20);
    cyc(0, 0, 0, 0, 1, 16'hFFFD, 26'd0, 32'd0);
    check("br_back", pc, 32'd3);
    check("br_back_inc4", pc4, 32'd12);
    cyc(1, 0, 0, 0, 0, 16'd0, 26'd7, 32'd0);
    check("jump7", pc, 32'd7);
    check("jump7_inc4", pc4, 32'd28);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd40, 32'd0);
    check("jal_pc", pc, 32'd40);
    check("jal_link", link_addr, 32'd8);
    check("jal_cnt", {29'd0, ras_count}, 32'd1);
    cyc(0, 0, 1, 0, 0, 16'd0, 26'd0, 32'd55);
    check("jr_plain_pc", pc, 32'd55);
    check("jr_plain_cnt", {29'd0, ras_count}, 32'd1);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd99);
    check("ret_pc", pc, 32'd8);
    check("ret_cnt", {29'd0, ras_count}, 32'd0);
    check("ret_link", link_addr, 32'd0);
    cyc(1, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("jump0", pc, 32'd0);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd10, 32'd0);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd20, 32'd0);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd30, 32'd0);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd40, 32'd0);
    check("full_cnt", {29'd0, ras_count}, 32'd4);
    check("full_ovf", {31'd0, ras_overflow}, 32'd0);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd50, 32'd0);
    check("ovf_pc", pc, 32'd50);
    check("ovf_cnt", {29'd0, ras_count}, 32'd4);
    check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
    check("ovf_link", link_addr, 32'd41);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd77);
    check("pop1", pc, 32'd41);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd77);
    check("pop2", pc, 32'd31);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd77);
    check("pop3", pc, 32'd21);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd77);
    check("pop4", pc, 32'd11);
    check("pop4_cnt", {29'd0, ras_count}, 32'd0);
    check("pop4_unf", {31'd0, ras_underflow}, 32'd0);
    cyc(0, 0, 1, 1, 0, 16'd0, 26'd0, 32'd77);
    check("pop5_pc", pc, 32'd77);
    check("pop5_unf", {31'd0, ras_underflow}, 32'd1);
    check("pop5_cnt", {29'd0, ras_count}, 32'd0);
    check("sticky_ovf", {31'd0, ras_overflow}, 32'd1);
    cyc(1, 0, 0, 0, 0, 16'd0, 26'd2, 32'd0);
    check("jump2", pc, 32'd2);
    cyc(1, 0, 0, 0, 1, 16'd5, 26'd9, 32'd0);
    check("jump_over_br", pc, 32'd9);
    cyc(1, 1, 0, 0, 0, 16'd0, 26'd2, 32'd0);
    check("jump_over_jal_pc", pc, 32'd2);
    check("jump_over_jal_cnt", {29'd0, ras_count}, 32'd0);
    stall = 1'b1;
    cyc(1, 0, 0, 0, 1, 16'd5, 26'd9, 32'd0);
    check("stall_pc", pc, 32'd2);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd9, 32'd0);
    check("stall_jal_pc", pc, 32'd2);
    check("stall_jal_cnt", {29'd0, ras_count}, 32'd0);
    stall = 1'b0;
    cyc(0, 0, 1, 0, 0, 16'd0, 26'd0, 32'hFFFF_FFFF);
    check("wrap_pre", pc, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("wrap", pc, 32'd0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    reset = 1'b0;
    check("rst2_ovf", {31'd0, ras_overflow}, 32'd0);
    check("rst2_unf", {31'd0, ras_underflow}, 32'd0);
`else
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
      check("ds_seq", pc, 32'(i));
    end
    cyc(1, 0, 0, 0, 0, 16'd0, 26'd30, 32'd0);
    check("ds_slot_pc", pc, 32'd5);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd60, 32'd0);
    check("ds_target", pc, 32'd30);
    check("ds_slot_jal_cnt", {29'd0, ras_count}, 32'd0);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("ds_after", pc, 32'd31);
    cyc(0, 1, 0, 0, 0, 16'd0, 26'd50, 32'd0);
    check("ds_jal_slot", pc, 32'd32);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("ds_jal_tgt", pc, 32'd50);
    check("ds_jal_link", link_addr, 32'd33);
    check("ds_jal_cnt", {29'd0, ras_count}, 32'd1);
    cyc(1, 0, 0, 0, 0, 16'd0, 26'd70, 32'd0);
    check("ds_rst_slot", pc, 32'd51);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    reset = 1'b0;
    check("ds_rst_pc", pc, 32'd0);
    cyc(0, 0, 0, 0, 0, 16'd0, 26'd0, 32'd0);
    check("ds_rst_drop", pc, 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
